// File: rtl/demo_streaming_0_st2mem.sv
// Avalon-ST sink to single-port RAM writer: one packet per start, wrapping at DEPTH.
// Optional ST2MEM_PROTO_CHECK_EN adds a sticky proto_err output and sop-restart handling.
module demo_streaming_0_st2mem #(
  parameter int DEPTH  = 5120,
  parameter int ADDR_W = 13,
  parameter int CNT_W  = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [CNT_W-1:0]  cfg_words,
  input  logic [31:0]       snk_data,
  input  logic              snk_valid,
  output logic              snk_ready,
  input  logic              snk_sop,
  input  logic              snk_eop,
  input  logic [1:0]        snk_empty,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic              mem_clken,
`ifdef ST2MEM_PROTO_CHECK_EN
  output logic              proto_err,
`endif
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  stat_words,
  output logic              stat_trunc
);

  typedef enum logic [2:0] {
    IDLE, WAIT_SOP, RUN, DRAIN, FIN
  } state_e;

  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [CNT_W-1:0]  limit_q, limit_d;
  logic [CNT_W-1:0]  words_q, words_d;
  logic              trunc_q, trunc_d;
  logic              perr_q, perr_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       data_q, data_d;
  logic              wr_q, wr_d;

  logic              acc;
  logic              restart;
  logic [ADDR_W-1:0] addr_wr;
  logic [CNT_W-1:0]  cnt_n;

  assign snk_ready = (state_q == WAIT_SOP) || (state_q == RUN) ||
                     (state_q == DRAIN);
  assign acc       = snk_valid && snk_ready;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    wptr_d  = wptr_q;
    limit_d = limit_q;
    words_d = words_q;
    trunc_d = trunc_q;
    perr_d  = perr_q;
    addr_d  = addr_q;
    be_d    = be_q;
    data_d  = data_q;
    wr_d    = 1'b0;
    restart = 1'b0;
    done_d  = (state_q == FIN);
`ifdef ST2MEM_PROTO_CHECK_EN
    if (acc && !snk_eop && snk_empty != 2'd0) perr_d = 1'b1;
    if (acc && snk_sop && state_q == RUN) begin
      restart = 1'b1;
      perr_d  = 1'b1;
    end
`endif
    cnt_n = restart ? CNT_W'(1) : words_q + CNT_W'(1);
    unique case (state_q)
      IDLE: begin
        if (start) begin
          base_d  = cfg_base;
          wptr_d  = cfg_base;
          limit_d = (cfg_words == '0) ? DEPTH_C : cfg_words;
          words_d = '0;
          trunc_d = 1'b0;
          perr_d  = 1'b0;
          state_d = WAIT_SOP;
        end
      end
      WAIT_SOP: begin
        if (acc && snk_sop) begin
          wr_d = 1'b1;
          if (snk_eop)                       state_d = FIN;
          else if (limit_q == CNT_W'(1))     state_d = DRAIN;
          else                               state_d = RUN;
        end
      end
      RUN: begin
        if (acc) begin
          wr_d = 1'b1;
          if (snk_eop)               state_d = FIN;
          else if (cnt_n == limit_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (acc && snk_eop) begin
          trunc_d = 1'b1;
          state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // The write port mirrors the accepted beat one cycle later
    addr_wr = restart ? base_q : wptr_q;
    if (wr_d) begin
      addr_d  = addr_wr;
      wptr_d  = (addr_wr == LAST_A) ? '0 : addr_wr + ADDR_W'(1);
      words_d = cnt_n;
      data_d  = snk_data;
      be_d    = snk_eop ? (4'hF << snk_empty) : 4'hF;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      base_q  <= '0;
      wptr_q  <= '0;
      limit_q <= '0;
      words_q <= '0;
      trunc_q <= 1'b0;
      perr_q  <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      wptr_q  <= wptr_d;
      limit_q <= limit_d;
      words_q <= words_d;
      trunc_q <= trunc_d;
      perr_q  <= perr_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
    end
  end

  assign mem_address    = addr_q;
  assign mem_byteenable = be_q;
  assign mem_chipselect = wr_q;
  assign mem_write      = wr_q;
  assign mem_writedata  = data_q;
  assign mem_clken      = 1'b1;
  assign busy           = (state_q != IDLE);
  assign done           = done_q;
  assign stat_words     = words_q;
  assign stat_trunc     = trunc_q;
`ifdef ST2MEM_PROTO_CHECK_EN
  assign proto_err      = perr_q;
`else
  logic unused_perr;
  assign unused_perr    = perr_q;
`endif

endmodule

// File: tb/tb_demo_streaming_0_st2mem.sv
// Scoreboard bench for demo_streaming_0_st2mem: packet-level model feeds an
// expected-write queue that an independent monitor drains.
module tb_demo_streaming_0_st2mem;
  localparam int DEPTH = 5120;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [12:0] cfg_base;
  logic [12:0] cfg_words;
  logic [31:0] snk_data;
  logic        snk_valid, snk_ready, snk_sop, snk_eop;
  logic [1:0]  snk_empty;
  logic [12:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_writedata;
  logic        busy, done, stat_trunc;
  logic [12:0] stat_words;
`ifdef ST2MEM_PROTO_CHECK_EN
  logic        proto_err;
`endif

  demo_streaming_0_st2mem dut (
    .clk(clk), .reset(rst), .start(start),
    .cfg_base(cfg_base), .cfg_words(cfg_words),
    .snk_data(snk_data), .snk_valid(snk_valid), .snk_ready(snk_ready),
    .snk_sop(snk_sop), .snk_eop(snk_eop), .snk_empty(snk_empty),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken),
`ifdef ST2MEM_PROTO_CHECK_EN
    .proto_err(proto_err),
`endif
    .busy(busy), .done(done),
    .stat_words(stat_words), .stat_trunc(stat_trunc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [12:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } wr_t;

  wr_t         expq[$];
  logic [31:0] bd[$];
  bit          bs[$], bee[$];
  logic [1:0]  bm[$];
  int          nchk = 0;
  int          nfail = 0;

  task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && mem_write) begin
      wr_t w;
      chk("write_expected", expq.size() != 0, 1);
      chk("no_done_with_write", done, 0);
      chk("chipselect", mem_chipselect, 1);
      if (expq.size() != 0) begin
        w = expq.pop_front();
        chk("wr_addr", mem_address, w.a);
        chk("wr_data", mem_writedata, w.d);
        chk("wr_be", mem_byteenable, w.be);
      end
    end
  end

  // Packet-level reference: what the RAM should receive for this beat list
  task automatic model(input int base, input int words,
                       output int ew, output bit et);
    int lim = (words == 0) ? DEPTH : words;
    bit started = 0;
    bit drain = 0;
    int cnt = 0;
    et = 0;
    for (int i = 0; i < bd.size(); i++) begin
      if (!started) begin
        if (!bs[i]) continue;
        started = 1;
      end
      if (drain) begin
        if (bee[i]) begin
          et = 1;
          break;
        end
        continue;
      end
      expq.push_back('{a: 13'((base + cnt) % DEPTH), d: bd[i],
                       be: bee[i] ? (4'hF << bm[i]) : 4'hF});
      cnt++;
      if (bee[i]) break;
      if (cnt == lim) drain = 1;
    end
    ew = cnt;
  endtask

  task automatic add_beat(logic [31:0] d, bit s, bit e, logic [1:0] m);
    bd.push_back(d);
    bs.push_back(s);
    bee.push_back(e);
    bm.push_back(m);
  endtask

  task automatic clr_beats();
    bd.delete(); bs.delete(); bee.delete(); bm.delete();
  endtask

  task automatic pulse_start(int base, int words);
    cfg_base  = 13'(base);
    cfg_words = 13'(words);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drive_beat(int i);
    bit ok = 0;
    snk_valid = 1'b1;
    snk_data  = bd[i];
    snk_sop   = bs[i];
    snk_eop   = bee[i];
    snk_empty = bm[i];
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (snk_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("beat_accept_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic run_pkt(int base, int words, int gap, bit mid_start);
    int ew;
    bit et;
    bit seen = 0;
    model(base, words, ew, et);
    pulse_start(base, words);
    chk("busy_after_start", busy, 1);
    for (int i = 0; i < bd.size(); i++) begin
      if ($urandom_range(99) < gap) begin
        snk_valid = 1'b0;
        @(posedge clk); #1;
      end
      if (mid_start && i == 2) begin
        cfg_base  = 13'($urandom_range(DEPTH - 1));
        cfg_words = 13'd1;
        start     = 1'b1;
      end
      drive_beat(i);
      start = 1'b0;
    end
    snk_valid = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
    end
    chk("done_seen", seen, 1);
    chk("stat_words", stat_words, ew);
    chk("stat_trunc", stat_trunc, et);
    chk("queue_drained", expq.size(), 0);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("idle_after", busy, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int base, words, len;
    rst = 1'b1; start = 1'b0; cfg_base = '0; cfg_words = '0;
    snk_data = '0; snk_valid = 1'b0; snk_sop = 1'b0;
    snk_eop = 1'b0; snk_empty = '0;
    #1;
    chk("rst_ready", snk_ready, 0);
    chk("rst_write", mem_write, 0);
    chk("rst_cs", mem_chipselect, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_be", mem_byteenable, 0);
    chk("rst_data", mem_writedata, 0);
    chk("rst_clken", mem_clken, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_words", stat_words, 0);
    chk("rst_trunc", stat_trunc, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    clr_beats();
    add_beat(32'h11111111, 1, 0, 0);
    add_beat(32'h22222222, 0, 0, 0);
    add_beat(32'h33333333, 0, 0, 0);
    add_beat(32'h44444444, 0, 1, 0);
    run_pkt(100, 8, 0, 0);

    clr_beats();
    for (int i = 0; i < 4; i++)
      add_beat(32'hA0 + 32'(i), i == 0, i == 3, 0);
    run_pkt(5118, 0, 0, 0);

    clr_beats();
    for (int i = 0; i < 6; i++)
      add_beat(32'hB0 + 32'(i), i == 0, i == 5, 0);
    run_pkt(40, 3, 0, 0);

    clr_beats();
    add_beat(32'hDEAD0001, 0, 0, 0);
    add_beat(32'hDEAD0002, 0, 0, 0);
    add_beat(32'hC0C0C0C0, 1, 0, 0);
    add_beat(32'hC1C1C1C1, 0, 1, 3);
    run_pkt(7, 0, 0, 0);

    clr_beats();
    add_beat(32'h55, 1, 1, 2);
    run_pkt(3000, 1, 0, 0);

    clr_beats();
    add_beat(32'hE0, 1, 0, 0);
    add_beat(32'hE1, 0, 1, 1);
    run_pkt(9, 2, 0, 0);

    // Reset lands while the second beat's write is pending
    expq.push_back('{a: 13'd200, d: 32'hF0, be: 4'hF});
    clr_beats();
    for (int i = 0; i < 8; i++)
      add_beat(32'hF0 + 32'(i), i == 0, i == 7, 0);
    pulse_start(200, 0);
    drive_beat(0);
    snk_valid = 1'b1;
    snk_data = bd[1]; snk_sop = 1'b0; snk_eop = 1'b0; snk_empty = 0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_write", mem_write, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", snk_ready, 0);
    chk("mid_rst_words", stat_words, 0);
    chk("mid_rst_queue", expq.size(), 0);
    snk_valid = 1'b0;
    expq.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    run_pkt(300, 0, 0, 0);

    for (int p = 0; p < 6; p++) begin
      base  = (p % 2) ? DEPTH - 1 - $urandom_range(4)
                      : $urandom_range(DEPTH - 1);
      words = $urandom_range(8);
      len   = $urandom_range(4, 12);
      clr_beats();
      for (int i = 0; i < len; i++)
        add_beat($urandom, i == 0, i == len - 1,
                 (i == len - 1) ? 2'($urandom_range(3)) : 2'd0);
      run_pkt(base, words, 50, p == 1 || p == 4);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end
endmodule
